cb_douta_router: RTL and testbench

CB_DOUTA_ROUTER -- requirements
Module: cb_douta_router

---
 rtl/cb_douta_router_if.sv | 28 ++
 rtl/cb_douta_router.sv | 158 +++++++++++++++
 tb/tb_cb_douta_router.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cb_douta_router_if.sv
// Bank-read to PE-port router bus: the input beat (sel, landmark, data) and the
// three mapped output ports with their one-hot valid and the shared ready.
interface cb_douta_router_if #(
    parameter int L       = 4,
    parameter int RSA_DW  = 16,
    parameter int ROW_LEN = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            CB_douta_sel;
    logic [ROW_LEN-1:0]    landmark_num;
    logic [L*RSA_DW-1:0]   CB_douta;
    logic [L*RSA_DW-1:0]   A_CB_douta;
    logic [L*RSA_DW-1:0]   B_CB_douta;
    logic [L*RSA_DW-1:0]   M_CB_douta;
    logic [2:0]            out_valid;
    logic                  out_ready;

    modport slave (
        input  in_valid, CB_douta_sel, landmark_num, CB_douta, out_ready,
        output in_ready, A_CB_douta, B_CB_douta, M_CB_douta, out_valid
    );

    modport master (
        output in_valid, CB_douta_sel, landmark_num, CB_douta, out_ready,
        input  in_ready, A_CB_douta, B_CB_douta, M_CB_douta, out_valid
    );
endinterface

// File: rtl/cb_douta_router.sv
// Routes a cache-bank read beat to the A/B/M PE port with POS/NEG/NEW lane remapping; 1-cycle
// registered latency, output reg + 1-entry skid (in_ready = skid empty). CB_DOUTA_ROUTER_STATS_EN adds beat/stall counters.
module cb_douta_router #(
    parameter int L       = 4,
    parameter int RSA_DW  = 16,
    parameter int ROW_LEN = 10,
    parameter int NEW_W   = 2
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               flush,
    cb_douta_router_if.slave   bus
`ifdef CB_DOUTA_ROUTER_STATS_EN
    ,
    output logic [31:0]        beat_cnt,
    output logic [31:0]        stall_cnt
`endif
);
    localparam int DW = L * RSA_DW;
    localparam int G  = L / NEW_W;
    localparam int KW = $clog2(2 * G);

    logic [2:0]    out_vld_q, out_vld_d;
    logic [DW-1:0] out_dat_q, out_dat_d;
    logic [2:0]    skid_vld_q, skid_vld_d;
    logic [DW-1:0] skid_dat_q, skid_dat_d;

    logic [2:0]    map_vld;
    logic [DW-1:0] map_dat;
    logic [KW-1:0] k;
    int            src;
    logic          skid_full;
    logic          drain;
    logic          load;

    // k = (landmark_num + 1) mod 2G falls out of the KW-bit wrap
    assign k         = bus.landmark_num[KW-1:0] + KW'(1);
    assign skid_full = |skid_vld_q;
    assign drain     = (|out_vld_q) && bus.out_ready;
    assign load      = bus.in_valid && !skid_full && (|map_vld);

    always_comb begin
        map_vld = 3'b000;
        unique case (bus.CB_douta_sel[3:2])
            2'b01:   map_vld = 3'b001;
            2'b10:   map_vld = 3'b010;
            2'b11:   map_vld = 3'b100;
            default: map_vld = 3'b000;
        endcase
    end

    always_comb begin
        map_dat = '0;
        src     = 0;
        unique case (bus.CB_douta_sel[1:0])
            2'b01: begin
                for (int i = 0; i < L; i++)
                    map_dat[i*RSA_DW +: RSA_DW] = bus.CB_douta[i*RSA_DW +: RSA_DW];
            end
            2'b10: begin
                for (int i = 0; i < L; i++)
                    map_dat[i*RSA_DW +: RSA_DW] = bus.CB_douta[(L-1-i)*RSA_DW +: RSA_DW];
            end
            2'b11: begin
                // upper half of the k range walks the groups backwards with lanes reversed
                for (int i = 0; i < NEW_W; i++) begin
                    if (int'(k) < G)
                        src = int'(k) * NEW_W + i;
                    else
                        src = (2*G - 1 - int'(k)) * NEW_W + NEW_W - 1 - i;
                    map_dat[i*RSA_DW +: RSA_DW] = bus.CB_douta[src*RSA_DW +: RSA_DW];
                end
            end
            default: map_dat = '0;
        endcase
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            out_vld_d  = '0;
            out_dat_d  = '0;
            skid_vld_d = '0;
            skid_dat_d = '0;
        end else if (!(|out_vld_q) || drain) begin
            if (skid_full) begin
                out_vld_d  = skid_vld_q;
                out_dat_d  = skid_dat_q;
                skid_vld_d = '0;
                skid_dat_d = '0;
            end else if (load) begin
                out_vld_d = map_vld;
                out_dat_d = map_dat;
            end else begin
                out_vld_d = '0;
                out_dat_d = '0;
            end
        end else if (load) begin
            skid_vld_d = map_vld;
            skid_dat_d = map_dat;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_vld_q  <= '0;
            out_dat_q  <= '0;
            skid_vld_q <= '0;
            skid_dat_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

    assign bus.in_ready   = !skid_full;
    assign bus.out_valid  = out_vld_q;
    assign bus.A_CB_douta = out_vld_q[0] ? out_dat_q : '0;
    assign bus.B_CB_douta = out_vld_q[1] ? out_dat_q : '0;
    assign bus.M_CB_douta = out_vld_q[2] ? out_dat_q : '0;

`ifdef CB_DOUTA_ROUTER_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
        end else begin
            if (drain)
                beat_cnt_d = beat_cnt_q + 32'd1;
            if ((|out_vld_q) && !bus.out_ready)
                stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_cb_douta_router.sv
// Scoreboard bench for cb_douta_router: directed beats push expected port values, a negedge
// monitor pops and compares on every output handshake; optional counters under CB_DOUTA_ROUTER_STATS_EN.
module tb_cb_douta_router;
    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    logic flush = 1'b0;
    logic flush8 = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [2:0]  v;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] m;
    } exp_t;
    exp_t sb[$];

    cb_douta_router_if #(.L(4), .RSA_DW(16), .ROW_LEN(10)) bus ();
    cb_douta_router_if #(.L(8), .RSA_DW(16), .ROW_LEN(10)) bus8 ();

`ifdef CB_DOUTA_ROUTER_STATS_EN
    logic [31:0] beat_cnt, stall_cnt, beat_cnt8, stall_cnt8;
`endif

    cb_douta_router #(.L(4), .RSA_DW(16), .ROW_LEN(10), .NEW_W(2)) dut (
        .clk(clk), .sys_rst(sys_rst), .flush(flush), .bus(bus)
`ifdef CB_DOUTA_ROUTER_STATS_EN
        , .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
`endif
    );

    cb_douta_router #(.L(8), .RSA_DW(16), .ROW_LEN(10), .NEW_W(2)) dut8 (
        .clk(clk), .sys_rst(sys_rst), .flush(flush8), .bus(bus8)
`ifdef CB_DOUTA_ROUTER_STATS_EN
        , .beat_cnt(beat_cnt8), .stall_cnt(stall_cnt8)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Monitor: one handshake per cycle, decided by the values seen at negedge
    always @(negedge clk) begin
        if (!sys_rst && (bus.out_valid != 3'b000) && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat got_valid=%0b want=none", bus.out_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_valid", 128'(bus.out_valid), 128'(e.v));
                check("A_data", 128'(bus.A_CB_douta), 128'(e.a));
                check("B_data", 128'(bus.B_CB_douta), 128'(e.b));
                check("M_data", 128'(bus.M_CB_douta), 128'(e.m));
            end
        end
    end

    // Drive one beat (called #1 after a posedge); returns #1 after the accepting edge
    task automatic send(input logic [3:0] sel, input logic [9:0] lm, input logic [63:0] d,
                        input logic [2:0] ev, input logic [63:0] ed, output int acc_cyc);
        logic rdy;
        int   n;
        exp_t e;
        bus.in_valid     = 1'b1;
        bus.CB_douta_sel = sel;
        bus.landmark_num = lm;
        bus.CB_douta     = d;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            n++;
        end
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=%0d want<50", n);
        end else if (ev != 3'b000) begin
            e.v = ev;
            e.a = ev[0] ? ed : 64'd0;
            e.b = ev[1] ? ed : 64'd0;
            e.m = ev[2] ? ed : 64'd0;
            sb.push_back(e);
        end
        #1;
        bus.in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic drain_wait();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        int c0, c1, cx;
        bus.in_valid = 1'b0;  bus.CB_douta_sel = 4'd0; bus.landmark_num = '0;
        bus.CB_douta = '0;    bus.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.CB_douta_sel = 4'd0; bus8.landmark_num = '0;
        bus8.CB_douta = '0;   bus8.out_ready = 1'b1;

        #1;
        check("rst_async_valid", 128'(bus.out_valid), 128'd0);
        repeat (2) @(posedge clk);
        #2 sys_rst = 1'b0;
        @(posedge clk); #1;
        check("rst_valid", 128'(bus.out_valid), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_data", 128'({bus.A_CB_douta, bus.B_CB_douta}), 128'd0);
        bus.out_ready = 1'b1;

        // POS to A, then check one-cycle latency directly
        send(4'b0101, 10'd0, 64'h0004_0003_0002_0001, 3'b001, 64'h0004_0003_0002_0001, c0);
        @(negedge clk);
        check("latency_valid", 128'(bus.out_valid), 128'(3'b001));
        @(posedge clk); #1;
        send(4'b1110, 10'd0, 64'h0004_0003_0002_0001, 3'b100, 64'h0001_0002_0003_0004, c0);
        send(4'b0100, 10'd0, 64'h0004_0003_0002_0001, 3'b001, 64'h0, c0);
        send(4'b0001, 10'd0, 64'h0004_0003_0002_0001, 3'b000, 64'h0, c0);
        @(negedge clk);
        check("drop_no_valid", 128'(bus.out_valid), 128'd0);
        @(posedge clk); #1;

        // NEW sweep back to back
        send(4'b1011, 10'd3, 64'h0028_001E_0014_000A, 3'b010, 64'h0000_0000_0014_000A, c0);
        send(4'b1011, 10'd4, 64'h0028_001E_0014_000A, 3'b010, 64'h0000_0000_0028_001E, cx);
        send(4'b1011, 10'd5, 64'h0028_001E_0014_000A, 3'b010, 64'h0000_0000_001E_0028, cx);
        send(4'b1011, 10'd6, 64'h0028_001E_0014_000A, 3'b010, 64'h0000_0000_000A_0014, c1);
        check("throughput_cycles", 128'(c1 - c0), 128'd3);
        drain_wait();

        // Flush with two buffered beats and a beat offered in the flush cycle
        bus.out_ready = 1'b0;
        send(4'b0101, 10'd0, 64'h1111, 3'b000, 64'h0, c0);
        send(4'b0101, 10'd0, 64'h2222, 3'b000, 64'h0, c0);
        flush = 1'b1;
        bus.in_valid = 1'b1; bus.CB_douta = 64'h3333;
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_valid", 128'(bus.out_valid), 128'd0);
        check("flush_data", 128'(bus.A_CB_douta), 128'd0);
        check("flush_in_ready", 128'(bus.in_ready), 128'd1);
`ifdef CB_DOUTA_ROUTER_STATS_EN
        check("flush_stall_cnt", 128'(stall_cnt), 128'd0);
`endif
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Stall: two beats buffer, third waits for in_ready
        bus.out_ready = 1'b0;
        send(4'b0101, 10'd0, 64'h00AA, 3'b001, 64'h00AA, c0);
        send(4'b1001, 10'd0, 64'h00BB, 3'b010, 64'h00BB, c0);
        check("stall_in_ready_low", 128'(bus.in_ready), 128'd0);
        bus.in_valid = 1'b1; bus.CB_douta_sel = 4'b1101; bus.CB_douta = 64'h00CC;
        repeat (3) @(posedge clk);
        #1;
        check("stall_still_blocked", 128'(bus.in_ready), 128'd0);
        check("stall_hold_valid", 128'(bus.out_valid), 128'(3'b001));
`ifdef CB_DOUTA_ROUTER_STATS_EN
        check("stall_cnt", 128'(stall_cnt), 128'd4);
`endif
        bus.out_ready = 1'b1;
        send(4'b1101, 10'd0, 64'h00CC, 3'b100, 64'h00CC, c0);
        drain_wait();
`ifdef CB_DOUTA_ROUTER_STATS_EN
        check("beat_cnt", 128'(beat_cnt), 128'd3);
`endif

        // L=8, landmark 6 -> k=7, g=0: lanes (0,1) from banks (1,0)
        bus8.in_valid = 1'b1; bus8.CB_douta_sel = 4'b1011; bus8.landmark_num = 10'd6;
        bus8.CB_douta = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        check("l8_valid", 128'(bus8.out_valid), 128'(3'b010));
        check("l8_B", bus8.B_CB_douta, 128'h0000_0000_0000_0000_0000_0000_0001_0002);
        check("l8_A", bus8.A_CB_douta, 128'd0);

        // Async reset with a beat in flight
        bus.out_ready = 1'b0;
        send(4'b0101, 10'd0, 64'h00DD, 3'b000, 64'h0, c0);
        #2 sys_rst = 1'b1;
        #1;
        check("arst_valid", 128'(bus.out_valid), 128'd0);
        check("arst_data", 128'(bus.A_CB_douta), 128'd0);
        @(posedge clk);
        #2 sys_rst = 1'b0;
        #1;
        check("arst_in_ready", 128'(bus.in_ready), 128'd1);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        drain_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
